// File: rtl/cordic_phase_gen.sv
// cordic_phase_gen: burst phase generator that feeds a CORDIC rotator with a
// quadrant-folded start vector and angle, and tracks rotator output validity.
//
// Ports:
//   clock, reset_n         rising-edge clock, asynchronous active-low reset
//   start, abort           burst start request / immediate burst cancel
//   phase_init, freq_word  starting phase and per-sample increment (65536 = 1 turn)
//   burst_len, rate_div    samples per burst / one sample every rate_div+1 cycles
//   freq_step              (CORDIC_PHASE_SWEEP_EN only) signed chirp step
//   x0, y0, z0             rotator start vector and residual angle (1 rad = 16384)
//   sample_valid           x0/y0/z0 carry a new sample this cycle
//   out_valid              rotator outputs valid, LATENCY cycles after sample_valid
//   busy, done             burst in progress / one-cycle completion pulse
//
// Optional feature: define CORDIC_PHASE_SWEEP_EN for a linear frequency chirp.
module cordic_phase_gen #(
    parameter int AMPLITUDE = 9949,
    parameter int LATENCY   = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] phase_init,
    input  logic [15:0] freq_word,
    input  logic [11:0] burst_len,
    input  logic [3:0]  rate_div,
`ifdef CORDIC_PHASE_SWEEP_EN
    input  logic [15:0] freq_step,
`endif
    output logic [15:0] x0,
    output logic [15:0] y0,
    output logic [15:0] z0,
    output logic        sample_valid,
    output logic        out_valid,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [15:0] P_AMP = 16'(AMPLITUDE);
    localparam logic [15:0] P_NEG = 16'(-AMPLITUDE);

    state_t              r_state;
    state_t              w_next;
    logic [15:0]         r_phase;
    logic [15:0]         r_freq;
    logic [11:0]         r_cnt;
    logic [3:0]          r_rate;
    logic [3:0]          r_div;
    logic                r_last;
    logic [LATENCY-1:0]  r_dly;
    logic [LATENCY-1:0]  r_mark;
`ifdef CORDIC_PHASE_SWEEP_EN
    logic [15:0]         r_step;
`endif

    logic               w_accept;
    logic               w_issue;
    logic               w_final;
    logic               w_abort;
    logic               w_empty;
    logic [LATENCY-1:0] w_vnext;
    logic [LATENCY-1:0] w_mnext;
    logic [1:0]         w_q;
    logic [15:0]        w_r;
    logic [15:0]        w_x;
    logic [15:0]        w_y;
    logic [15:0]        w_z;

    assign w_accept = (r_state == IDLE) && start && (burst_len != 12'd0) && !abort;
    assign w_issue  = (r_state == RUN) && (r_div == 4'd0) && !abort;
    assign w_final  = w_issue && (r_cnt == 12'd1);
    assign w_abort  = abort && (r_state != IDLE);

    // Delay line and last-sample marker; the top bit drops off as it becomes out_valid.
    assign w_vnext = LATENCY'({r_dly, sample_valid});
    assign w_mnext = LATENCY'({r_mark, r_last});
    // Empty once nothing but the bit currently presented on out_valid remains.
    assign w_empty = ~|w_vnext;

    // Fold the phase into the quadrant nearest it, leaving a residual of +/- 1/8 turn.
    assign w_q = 2'((r_phase + 16'h2000) >> 14);
    assign w_r = r_phase - {w_q, 14'd0};
    // Turns-to-radians scaling: 25736 / 16384 ~= 2*pi / 4; >>> floors toward -inf.
    assign w_z = 16'((30'($signed(w_r)) * 30'sd25736) >>> 14);
    assign w_x = (w_q == 2'd0) ? P_AMP : (w_q == 2'd2) ? P_NEG : 16'd0;
    assign w_y = (w_q == 2'd1) ? P_AMP : (w_q == 2'd3) ? P_NEG : 16'd0;

    assign busy      = (r_state != IDLE);
    assign out_valid = r_dly[LATENCY-1];
    assign done      = r_dly[LATENCY-1] & r_mark[LATENCY-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? RUN : IDLE;
            RUN:     w_next = abort ? IDLE : (w_final ? DRAIN : RUN);
            DRAIN:   w_next = (abort || w_empty) ? IDLE : DRAIN;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_phase      <= '0;
            r_freq       <= '0;
            r_cnt        <= '0;
            r_rate       <= '0;
            r_div        <= '0;
            r_last       <= 1'b0;
            r_dly        <= '0;
            r_mark       <= '0;
            x0           <= '0;
            y0           <= '0;
            z0           <= '0;
            sample_valid <= 1'b0;
`ifdef CORDIC_PHASE_SWEEP_EN
            r_step       <= '0;
`endif
        end else begin
            sample_valid <= w_issue;
            r_last       <= w_final;
            r_dly        <= w_abort ? '0 : w_vnext;
            r_mark       <= w_abort ? '0 : w_mnext;
            if (w_accept) begin
                r_phase <= phase_init;
                r_freq  <= freq_word;
                r_cnt   <= burst_len;
                r_rate  <= rate_div;
                r_div   <= 4'd0;
`ifdef CORDIC_PHASE_SWEEP_EN
                r_step  <= freq_step;
`endif
            end else if (r_state == RUN) begin
                r_div <= (r_div == r_rate) ? 4'd0 : r_div + 4'd1;
            end
            if (w_issue) begin
                x0      <= w_x;
                y0      <= w_y;
                z0      <= w_z;
                r_phase <= r_phase + r_freq;
                r_cnt   <= r_cnt - 12'd1;
`ifdef CORDIC_PHASE_SWEEP_EN
                r_freq  <= r_freq + r_step;
`endif
            end
        end
    end
endmodule

// File: tb/tb_cordic_phase_gen.sv
// tb_cordic_phase_gen: table-driven scoreboard bench for cordic_phase_gen.
module tb_cordic_phase_gen;
    localparam int LAT = 16;
    localparam int AMP = 9949;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] phase_init = '0;
    logic [15:0] freq_word = '0;
    logic [11:0] burst_len = '0;
    logic [3:0]  rate_div = '0;
`ifdef CORDIC_PHASE_SWEEP_EN
    logic [15:0] freq_step = '0;
`endif
    logic [15:0] x0, y0, z0;
    logic        sample_valid, out_valid, busy, done;

    cordic_phase_gen #(.AMPLITUDE(AMP), .LATENCY(LAT)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
        .phase_init(phase_init), .freq_word(freq_word), .burst_len(burst_len),
        .rate_div(rate_div),
`ifdef CORDIC_PHASE_SWEEP_EN
        .freq_step(freq_step),
`endif
        .x0(x0), .y0(y0), .z0(z0), .sample_valid(sample_valid),
        .out_valid(out_valid), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic signed [15:0] x, y, z;
        logic               last;
        int                 cyc;
    } exp_t;

    typedef struct {
        int   cyc;
        logic last;
    } ov_t;

    typedef struct {
        logic [15:0]       ph, fw, st;
        logic [11:0]       len;
        logic [3:0]        rd;
        int                nc;
        logic [3:0][15:0]  cx, cy, cz;
    } vec_t;

    exp_t exp_q[$];
    ov_t  ov_q[$];
    vec_t vt[$];
    int   cmp = 0, err = 0, cyc = 0, n_done = 0;

    always @(posedge clock) cyc++;

    task automatic chk(input string n, input int a, input int e);
        cmp++;
        if (a != e) begin
            err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", n, a, e, cyc);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        ov_t  o;
        if (sample_valid) begin
            if (exp_q.size() == 0) chk("spurious sample_valid", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("x0", int'($signed(x0)), int'(e.x));
                chk("y0", int'($signed(y0)), int'(e.y));
                chk("z0", int'($signed(z0)), int'(e.z));
                chk("issue cycle", cyc, e.cyc);
                ov_q.push_back('{cyc: cyc, last: e.last});
            end
        end
        if (out_valid) begin
            if (ov_q.size() == 0) chk("spurious out_valid", 1, 0);
            else begin
                o = ov_q.pop_front();
                chk("out_valid latency", cyc - o.cyc, LAT);
                chk("done with final out_valid", int'(done), int'(o.last));
            end
        end else if (done) chk("done without out_valid", 1, 0);
        if (done) n_done++;
    end

    function automatic vec_t mk(input logic [15:0] ph, fw, input logic [11:0] len,
                                input logic [3:0] rd, input logic [15:0] st, input int nc,
                                input logic [3:0][15:0] cx, cy, cz);
        vec_t v;
        v.ph = ph; v.fw = fw; v.len = len; v.rd = rd; v.st = st;
        v.nc = nc; v.cx = cx; v.cy = cy; v.cz = cz;
        return v;
    endfunction

    task automatic launch(input vec_t v, input bit acc);
        exp_t        e;
        logic [15:0] p, f;
        int          s, q, r;
        @(negedge clock);
        phase_init = v.ph; freq_word = v.fw; burst_len = v.len; rate_div = v.rd;
`ifdef CORDIC_PHASE_SWEEP_EN
        freq_step = v.st;
`endif
        start = 1'b1;
        s = cyc + 1;
        p = v.ph;
        f = v.fw;
        for (int i = 0; acc && i < int'(v.len); i++) begin
            if (p >= 16'hE000 || p < 16'h2000) q = 0;
            else if (p < 16'h6000) q = 1;
            else if (p < 16'hA000) q = 2;
            else q = 3;
            r = int'(p) - q * 16384;
            if (r > 32767) r -= 65536;
            e.z = 16'((r * 25736) >>> 14);
            e.x = (q == 0) ? 16'(AMP) : (q == 2) ? 16'(-AMP) : 16'd0;
            e.y = (q == 1) ? 16'(AMP) : (q == 3) ? 16'(-AMP) : 16'd0;
            if (i < v.nc) begin
                e.x = v.cx[i]; e.y = v.cy[i]; e.z = v.cz[i];
            end
            e.last = (i == int'(v.len) - 1);
            e.cyc  = s + 1 + i * (int'(v.rd) + 1);
            exp_q.push_back(e);
            p = p + f;
            f = f + v.st;
        end
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget, input int d0);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clock);
            k++;
        end
        chk("burst ends within budget", int'(busy), 0);
        chk("one done pulse", n_done - d0, 1);
        chk("all samples seen", exp_q.size(), 0);
        chk("all out_valid seen", ov_q.size(), 0);
    endtask

    initial begin
        int d0;
        vec_t v;
        vt.push_back(mk(16'h0000, 16'h4000, 4, 0, 0, 4,
                        {16'd0, 16'(-9949), 16'd0, 16'd9949},
                        {16'(-9949), 16'd0, 16'd9949, 16'd0}, '0));
        vt.push_back(mk(16'h2000, 16'h0000, 1, 0, 0, 1, '0, {48'd0, 16'd9949}, {48'd0, 16'(-12868)}));
        vt.push_back(mk(16'h1FFF, 16'h0000, 1, 0, 0, 1, {48'd0, 16'd9949}, '0, {48'd0, 16'd12866}));
        vt.push_back(mk(16'h0000, 16'h0000, 3, 2, 0, 0, '0, '0, '0));
        vt.push_back(mk(16'hE000, 16'h1234, 20, 1, 0, 0, '0, '0, '0));
        vt.push_back(mk(16'hFFFF, 16'h0FFF, 30, 0, 0, 0, '0, '0, '0));
        vt.push_back(mk(16'h6000, 16'h8001, 5, 15, 0, 0, '0, '0, '0));
        vt.push_back(mk(16'hA000, 16'h2000, 8, 3, 0, 0, '0, '0, '0));
`ifdef CORDIC_PHASE_SWEEP_EN
        vt.push_back(mk(16'h0000, 16'h0000, 3, 0, 16'h1000, 3,
                        {16'd0, 16'd9949, 16'd9949, 16'd9949}, '0, {16'd0, 16'd6434, 16'd0, 16'd0}));
        vt.push_back(mk(16'hC000, 16'h0100, 40, 0, 16'hFF80, 0, '0, '0, '0));
`endif
        repeat (3) @(negedge clock);
        chk("reset x0", int'(x0), 0);
        chk("reset y0", int'(y0), 0);
        chk("reset z0", int'(z0), 0);
        chk("reset sample_valid", int'(sample_valid), 0);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        foreach (vt[i]) begin
            d0 = n_done;
            launch(vt[i], 1'b1);
            wait_end(int'(vt[i].len) * (int'(vt[i].rd) + 1) + LAT + 10, d0);
        end
        // burst_len == 0 is ignored
        d0 = n_done;
        launch(mk(16'h1234, 16'h0100, 0, 0, 0, 0, '0, '0, '0), 1'b0);
        chk("zero-length start ignored", int'(busy), 0);
        repeat (LAT + 4) @(negedge clock);
        chk("zero-length no done", n_done - d0, 0);
        // abort beats start in the same cycle
        abort = 1'b1;
        launch(mk(16'h1234, 16'h0100, 5, 0, 0, 0, '0, '0, '0), 1'b0);
        abort = 1'b0;
        chk("abort beats start", int'(busy), 0);
        repeat (LAT + 4) @(negedge clock);
        // start while busy is ignored
        d0 = n_done;
        launch(mk(16'h1000, 16'h0100, 10, 1, 0, 0, '0, '0, '0), 1'b1);
        repeat (3) @(negedge clock);
        launch(mk(16'h7777, 16'h0333, 5, 0, 0, 0, '0, '0, '0), 1'b0);
        wait_end(10 * 2 + LAT + 10, d0);
        // abort five cycles into a 100-sample burst
        d0 = n_done;
        launch(mk(16'h0000, 16'h0123, 100, 0, 0, 0, '0, '0, '0), 1'b1);
        repeat (4) @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("abort clears sample_valid", int'(sample_valid), 0);
        chk("abort clears out_valid", int'(out_valid), 0);
        chk("abort to IDLE", int'(busy), 0);
        exp_q.delete();
        ov_q.delete();
        repeat (LAT + 5) @(negedge clock);
        chk("abort no done", n_done - d0, 0);
        // reset mid-DRAIN
        launch(mk(16'h3000, 16'h0800, 3, 0, 0, 0, '0, '0, '0), 1'b1);
        repeat (6) @(negedge clock);
        chk("in DRAIN before reset", int'(busy), 1);
        reset_n = 1'b0;
        #1;
        chk("mid-drain reset x0", int'(x0), 0);
        chk("mid-drain reset y0", int'(y0), 0);
        chk("mid-drain reset z0", int'(z0), 0);
        chk("mid-drain reset out_valid", int'(out_valid), 0);
        chk("mid-drain reset busy", int'(busy), 0);
        chk("mid-drain reset done", int'(done), 0);
        exp_q.delete();
        ov_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        repeat (LAT + 5) @(negedge clock);
        d0 = n_done;
        v = mk(16'h5000, 16'h0400, 6, 1, 0, 0, '0, '0, '0);
        launch(v, 1'b1);
        wait_end(6 * 2 + LAT + 10, d0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule

// File: doc/cordic_phase_gen.md
CORDIC_PHASE_GEN -- requirements
Module: cordic_phase_gen

Interface
REQ-001 SHALL have parameter AMPLITUDE, default 9949, meaning magnitude driven on x0/y0 so that the rotator output has a magnitude of about 16384.
REQ-002 SHALL have parameter LATENCY, default 16, meaning the rotator pipeline depth in cycles that out_valid is aligned to.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle burst start request.
REQ-006 SHALL have port abort  input  1  immediate burst cancel.
REQ-007 SHALL have port phase_init  input  16  starting phase; unsigned turns, 65536 = one full turn.
REQ-008 SHALL have port freq_word  input  16  phase increment per issued sample.
REQ-009 SHALL have port burst_len  input  12  number of samples in the burst.
REQ-010 SHALL have port rate_div  input  4  issue one sample every rate_div+1 cycles.
REQ-011 SHALL have port x0, y0  output  16 each  signed rotator start vector.
REQ-012 SHALL have port z0  output  16  signed rotator angle; 1 rad = 16384.
REQ-013 SHALL have port sample_valid  output  1  x0/y0/z0 hold a new sample this cycle.
REQ-014 SHALL have port out_valid  output  1  marks the rotator cosine/sine outputs as valid, LATENCY cycles after sample_valid.
REQ-015 SHALL have port busy  output  1  high in RUN and DRAIN.
REQ-016 SHALL have port done  output  1  one-cycle pulse at burst completion.

Function
REQ-017 SHALL implement FSM states IDLE, RUN and DRAIN.
REQ-018 SHALL, on start in IDLE with burst_len != 0, load phase = phase_init, latch freq_word, burst_len and rate_div, clear the divider, and enter RUN.
REQ-019 SHALL ignore start when burst_len == 0 or when the FSM is not in IDLE.
REQ-020 SHALL, in RUN, issue a sample on each cycle in which the divider equals 0, with the divider counting 0..rate_div and wrapping; the first sample is issued one cycle after start is accepted.
REQ-021 SHALL, on each issued sample, register x0/y0/z0 from the current phase, pulse sample_valid, set phase = phase + freq_word modulo 2^16, and decrement the remaining-sample count.
REQ-022 SHALL map phase to outputs as follows: q = (phase + 0x2000)[15:14]; r = signed 16-bit (phase - q*0x4000), with r in [-8192, 8191]; z0 = (r * 25736) >>> 14, truncated toward minus infinity, so |z0| <= 12868.
REQ-023 SHALL drive (x0, y0) as (AMPLITUDE, 0) for q=0, (0, AMPLITUDE) for q=1, (-AMPLITUDE, 0) for q=2 and (0, -AMPLITUDE) for q=3.
REQ-024 SHALL, after the last sample is issued, go from RUN to DRAIN.
REQ-025 SHALL, in DRAIN, return to IDLE once the valid delay line is empty.
REQ-026 SHALL hold x0/y0/z0 at their last values when sample_valid is low.
REQ-027 SHALL produce out_valid as sample_valid delayed by exactly LATENCY cycles through a shift register; a last-sample marker shifts alongside it.
REQ-028 SHALL assert done in the same cycle as the out_valid of the final sample, for exactly one cycle.
REQ-029 SHALL, on abort in RUN or DRAIN, stop issuing samples, clear the delay line and marker, go to IDLE the next cycle, and not pulse done.
REQ-030 SHALL give abort priority over start when both are asserted in the same cycle.
REQ-031 SHALL wrap phase modulo 2^16 silently, with no error indication.

Reset
REQ-032 SHALL, while reset_n is low, asynchronously set state = IDLE and clear phase, divider, counters, delay line, x0, y0, z0, sample_valid, out_valid, busy and done to 0.
REQ-033 SHALL, on reset mid-burst, discard all in-flight samples; out_valid stays 0 after reset_n is released.

Configuration
REQ-034 SHALL, when CORDIC_PHASE_SWEEP_EN is defined, add input freq_step (16, signed), latch it at start, and add it to the working freq_word, modulo 2^16, after every issued sample (linear chirp).
REQ-035 SHALL, when CORDIC_PHASE_SWEEP_EN is undefined, omit freq_step and keep freq_word constant for the whole burst.

Verification
REQ-036 SHALL cover: phase_init=0x0000, freq_word=0x4000, burst_len=4, rate_div=0 -> (x0,y0,z0) = (9949,0,0), (0,9949,0), (-9949,0,0), (0,-9949,0) on consecutive cycles.
REQ-037 SHALL cover: phase_init=0x2000, burst_len=1 -> x0=0, y0=9949, z0=-12868; phase_init=0x1FFF -> x0=9949, y0=0, z0=12866.
REQ-038 SHALL cover: burst_len=3, rate_div=2 -> sample_valid high every 3rd cycle starting 1 cycle after start; out_valid follows 16 cycles after each sample_valid; done coincides with the 3rd out_valid.
REQ-039 SHALL cover: abort 5 cycles into a 100-sample burst -> sample_valid and out_valid cleared, IDLE on the next cycle, no done pulse.
REQ-040 SHALL cover: reset_n low mid-DRAIN -> all outputs 0 immediately; a new start after release runs a clean burst.
REQ-041 SHALL cover, with CORDIC_PHASE_SWEEP_EN defined: freq_word=0, freq_step=0x1000, burst_len=3 -> issued phases 0x0000, 0x0000, 0x1000.
